// File: rtl/pwm_pkg.sv
// pwm_pkg: shared width, period constant and controller state encoding
// for the PWM ramp controller slice.
package pwm_pkg;

   localparam int DUTY_W_DFLT = 12;
   localparam int PERIOD_MAX  = (1 << DUTY_W_DFLT) - 1;

   typedef enum logic [1:0] {
      IDLE,
      RAMP,
      DECEL,
      DEAD
   } state_e;

endpackage

// File: rtl/pwm_period_timer.sv
// pwm_period_timer: free-running period counter shared in phase with the
// PWM driver, period tick and ramp-update strobe.
module pwm_period_timer
   import pwm_pkg::*;
#(
   parameter int DUTY_W   = DUTY_W_DFLT,
   parameter int RAMP_DIV = 4
) (
   input  logic CLK,
   input  logic RST,
   output logic tick_o,
   output logic upd_o
);

   localparam int PW = (RAMP_DIV > 1) ? $clog2(RAMP_DIV) : 1;
   localparam logic [DUTY_W-1:0] CNT_MAX = '1;
   localparam logic [PW-1:0]     PRE_MAX = PW'(RAMP_DIV - 1);

   logic [DUTY_W-1:0] cnt_q, cnt_d;
   logic [PW-1:0]     pre_q, pre_d;

   assign tick_o = ~RST & (cnt_q == CNT_MAX);
   assign upd_o  = tick_o & (pre_q == PRE_MAX);

   always_comb begin
      cnt_d = cnt_q + DUTY_W'(1);
      pre_d = pre_q;
      if (tick_o) begin
         pre_d = (pre_q == PRE_MAX) ? '0 : pre_q + PW'(1);
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         cnt_q <= '0;
         pre_q <= '0;
      end else begin
         cnt_q <= cnt_d;
         pre_q <= pre_d;
      end
   end

endmodule

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl: period-aligned duty ramping with reversal dead time.
// Optional emergency stop input under PWM_RAMP_ESTOP_EN.
module pwm_ramp_ctrl
   import pwm_pkg::*;
#(
   parameter int DUTY_W           = DUTY_W_DFLT,
   parameter int STEP             = 16,
   parameter int RAMP_DIV         = 4,
   parameter int DEADTIME_PERIODS = 8
) (
   input  logic              CLK,
   input  logic              RST,
`ifdef PWM_RAMP_ESTOP_EN
   input  logic              ESTOP,
`endif
   input  logic              CMD_VALID,
   output logic              CMD_READY,
   input  logic [DUTY_W-1:0] CMD_DUTY,
   input  logic              CMD_DIR,
   output logic [DUTY_W-1:0] DUTY_CYC,
   output logic              DIR,
   output logic              PERIOD_TICK,
   output logic              BUSY,
   output logic              DONE
);

   localparam int DW = $clog2(DEADTIME_PERIODS + 1);
   localparam logic [DUTY_W:0] STEP_X  = (DUTY_W + 1)'(STEP);
   localparam logic [DW-1:0]   DEAD_LD = DW'(DEADTIME_PERIODS);

   state_e            state_q, state_d;
   logic [DUTY_W-1:0] duty_q, duty_d;
   logic [DUTY_W-1:0] tgt_q, tgt_d;
   logic [DUTY_W-1:0] pend_q, pend_d;
   logic [DW-1:0]     dead_q, dead_d;
   logic              dir_q, dir_d;
   logic              tdir_q, tdir_d;
   logic              done_q, done_d;
   logic [DUTY_W-1:0] nxt;
   logic              tick, upd, accept, estop;

   pwm_period_timer #(
      .DUTY_W  (DUTY_W),
      .RAMP_DIV(RAMP_DIV)
   ) u_timer (
      .CLK   (CLK),
      .RST   (RST),
      .tick_o(tick),
      .upd_o (upd)
   );

`ifdef PWM_RAMP_ESTOP_EN
   assign estop = ESTOP;
`else
   assign estop = 1'b0;
`endif

   // Saturating step at DUTY_W+1 bits: never overshoots tgt, never wraps.
   function automatic logic [DUTY_W-1:0] step_to(
      input logic [DUTY_W-1:0] cur,
      input logic [DUTY_W-1:0] tgt
   );
      logic [DUTY_W:0] c, t;
      c = {1'b0, cur};
      t = {1'b0, tgt};
      if (c < t) begin
         step_to = (c + STEP_X >= t) ? tgt : cur + STEP_X[DUTY_W-1:0];
      end else begin
         step_to = (c <= t + STEP_X) ? tgt : cur - STEP_X[DUTY_W-1:0];
      end
   endfunction

   assign nxt = step_to(duty_q, (state_q == DECEL) ? '0 : tgt_q);

   assign CMD_READY = ~RST & ~estop &
                      ((state_q == IDLE) | (state_q == RAMP));
   assign accept    = CMD_VALID & CMD_READY;

   always_comb begin
      state_d = state_q;
      duty_d  = duty_q;
      tgt_d   = tgt_q;
      pend_d  = pend_q;
      dead_d  = dead_q;
      dir_d   = dir_q;
      tdir_d  = tdir_q;
      done_d  = 1'b0;
      unique case (state_q)
         IDLE, RAMP: begin
            if (accept) begin
               tdir_d = CMD_DIR;
               if (CMD_DIR == dir_q || duty_q == '0) begin
                  tgt_d = CMD_DUTY;
                  if (CMD_DUTY == duty_q) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = RAMP;
                  end
               end else begin
                  pend_d  = CMD_DUTY;
                  state_d = DECEL;
               end
            end else begin
               // Direction only changes at a boundary while duty is zero.
               if (tick && duty_q == '0) begin
                  dir_d = tdir_q;
               end
               if (upd && state_q == RAMP) begin
                  duty_d = nxt;
                  if (nxt == tgt_q) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end
               end
            end
         end
         DECEL: begin
            if (upd) begin
               duty_d = nxt;
               if (nxt == '0) begin
                  dead_d  = DEAD_LD;
                  state_d = DEAD;
               end
            end
         end
         DEAD: begin
            if (tick) begin
               if (dead_q <= DW'(1)) begin
                  dead_d = '0;
                  dir_d  = tdir_q;
                  tgt_d  = pend_q;
                  if (pend_q == '0) begin
                     state_d = IDLE;
                     done_d  = 1'b1;
                  end else begin
                     state_d = RAMP;
                  end
               end else begin
                  dead_d = dead_q - DW'(1);
               end
            end
         end
         default: state_d = IDLE;
      endcase
      if (estop) begin
         state_d = IDLE;
         duty_d  = '0;
         tgt_d   = '0;
         pend_d  = '0;
         dead_d  = '0;
         tdir_d  = dir_q;
         dir_d   = dir_q;
         done_d  = 1'b0;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         duty_q  <= '0;
         tgt_q   <= '0;
         pend_q  <= '0;
         dead_q  <= '0;
         dir_q   <= 1'b0;
         tdir_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         duty_q  <= duty_d;
         tgt_q   <= tgt_d;
         pend_q  <= pend_d;
         dead_q  <= dead_d;
         dir_q   <= dir_d;
         tdir_q  <= tdir_d;
         done_q  <= done_d;
      end
   end

   assign DUTY_CYC    = duty_q;
   assign DIR         = dir_q;
   assign DONE        = done_q;
   assign BUSY        = (state_q != IDLE);
   assign PERIOD_TICK = tick;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl: scoreboard bench; three instances share one clock so
// their long PWM periods overlap. ESTOP cases need PWM_RAMP_ESTOP_EN.
`timescale 1ns/1ps
module tb_pwm_ramp_ctrl;
   import pwm_pkg::*;

   localparam int W   = 12;
   localparam int N   = 3;
   localparam int TMO = 12 * (PERIOD_MAX + 1);

   typedef struct {
      int id;
      int duty;
      int dir;
      int done;
      int gap;
      bit align;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst   [N];
   logic         vld   [N];
   logic [W-1:0] cduty [N];
   logic         cdir  [N];
   logic         rdy   [N];
   logic [W-1:0] duty  [N];
   logic         dir   [N];
   logic         tick  [N];
   logic         busy  [N];
   logic         done  [N];
`ifdef PWM_RAMP_ESTOP_EN
   logic         estop;
`endif

   int   errors;
   int   checks;
   exp_t sb [$];
   bit   mon_en [N];

   always #5 clk = ~clk;

   pwm_ramp_ctrl #(
      .DUTY_W(W), .STEP(256), .RAMP_DIV(1), .DEADTIME_PERIODS(2)
   ) u_a (
      .CLK(clk), .RST(rst[0]),
`ifdef PWM_RAMP_ESTOP_EN
      .ESTOP(1'b0),
`endif
      .CMD_VALID(vld[0]), .CMD_READY(rdy[0]),
      .CMD_DUTY(cduty[0]), .CMD_DIR(cdir[0]),
      .DUTY_CYC(duty[0]), .DIR(dir[0]), .PERIOD_TICK(tick[0]),
      .BUSY(busy[0]), .DONE(done[0])
   );

   pwm_ramp_ctrl #(
      .DUTY_W(W), .STEP(1024), .RAMP_DIV(1), .DEADTIME_PERIODS(2)
   ) u_b (
      .CLK(clk), .RST(rst[1]),
`ifdef PWM_RAMP_ESTOP_EN
      .ESTOP(1'b0),
`endif
      .CMD_VALID(vld[1]), .CMD_READY(rdy[1]),
      .CMD_DUTY(cduty[1]), .CMD_DIR(cdir[1]),
      .DUTY_CYC(duty[1]), .DIR(dir[1]), .PERIOD_TICK(tick[1]),
      .BUSY(busy[1]), .DONE(done[1])
   );

   pwm_ramp_ctrl #(
      .DUTY_W(W), .STEP(256), .RAMP_DIV(1), .DEADTIME_PERIODS(2)
   ) u_c (
      .CLK(clk), .RST(rst[2]),
`ifdef PWM_RAMP_ESTOP_EN
      .ESTOP(estop),
`endif
      .CMD_VALID(vld[2]), .CMD_READY(rdy[2]),
      .CMD_DUTY(cduty[2]), .CMD_DIR(cdir[2]),
      .DUTY_CYC(duty[2]), .DIR(dir[2]), .PERIOD_TICK(tick[2]),
      .BUSY(busy[2]), .DONE(done[2])
   );

   task automatic chk(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
      end
   endtask

   task automatic push(input int id, input int d, input int r,
                       input int dn, input int g, input bit al);
      exp_t e;
      e.id    = id;
      e.duty  = d;
      e.dir   = r;
      e.done  = dn;
      e.gap   = g;
      e.align = al;
      sb.push_back(e);
   endtask

   function automatic int pending(input int id);
      int n = 0;
      foreach (sb[i]) if (sb[i].id == id) n++;
      return n;
   endfunction

   task automatic drain(input int id, input string nm);
      int n = 0;
      while (pending(id) != 0 && n < TMO) begin
         @(negedge clk);
         n++;
      end
      if (pending(id) != 0) begin
         checks++;
         errors++;
         $display("FAIL %s: %0d events outstanding after %0d cycles",
                  nm, pending(id), n);
      end
   endtask

   task automatic tick_wait(input int id, input int n);
      int seen = 0;
      int cyc  = 0;
      while (seen < n && cyc < TMO) begin
         @(negedge clk);
         cyc++;
         if (tick[id]) seen++;
      end
      if (seen < n) begin
         checks++;
         errors++;
         $display("FAIL tick_wait%0d: got %0d ticks, expected %0d",
                  id, seen, n);
      end
   endtask

   task automatic send(input int id, input int d, input int r);
      @(negedge clk);
      chk($sformatf("ready_before_cmd%0d", id), int'(rdy[id]), 1);
      vld[id]   = 1'b1;
      cduty[id] = W'(d);
      cdir[id]  = r[0];
      @(negedge clk);
      vld[id] = 1'b0;
   endtask

   // Monitor: any change of DUTY_CYC/DIR or a DONE pulse is an event.
   initial begin : monitor
      int           gap_c [N];
      bit           ptick [N];
      logic [W-1:0] pduty [N];
      logic         pdir  [N];
      exp_t         e;
      int           idx;
      for (int k = 0; k < N; k++) begin
         gap_c[k] = 0;
         ptick[k] = 1'b0;
         pduty[k] = '0;
         pdir[k]  = 1'b0;
      end
      forever begin
         @(negedge clk);
         for (int k = 0; k < N; k++) begin
            if (mon_en[k] && (duty[k] != pduty[k] ||
                dir[k] != pdir[k] || done[k] === 1'b1)) begin
               idx = -1;
               foreach (sb[i]) if (idx < 0 && sb[i].id == k) idx = i;
               checks++;
               if (idx < 0) begin
                  errors++;
                  $display("FAIL dut%0d_unexpected: duty=%0d dir=%0d done=%0d, no event expected",
                           k, duty[k], dir[k], done[k]);
               end else begin
                  e = sb[idx];
                  sb.delete(idx);
                  if (int'(duty[k]) != e.duty || int'(dir[k]) != e.dir ||
                      int'(done[k]) != e.done ||
                      (e.gap != 0 && gap_c[k] != e.gap) ||
                      (e.align && !ptick[k])) begin
                     errors++;
                     $display("FAIL dut%0d_event: duty=%0d dir=%0d done=%0d gap=%0d aligned=%0d, expected duty=%0d dir=%0d done=%0d gap=%0d aligned=%0d",
                              k, duty[k], dir[k], done[k], gap_c[k], ptick[k],
                              e.duty, e.dir, e.done, e.gap, e.align);
                  end
               end
               gap_c[k] = 0;
            end
            if (tick[k] === 1'b1) gap_c[k]++;
            ptick[k] = (tick[k] === 1'b1);
            pduty[k] = duty[k];
            pdir[k]  = dir[k];
         end
      end
   end

   initial begin
      errors = 0;
      checks = 0;
      for (int k = 0; k < N; k++) begin
         rst[k]    = 1'b1;
         vld[k]    = 1'b0;
         cduty[k]  = '0;
         cdir[k]   = 1'b0;
         mon_en[k] = 1'b0;
      end
`ifdef PWM_RAMP_ESTOP_EN
      estop = 1'b0;
`endif
      repeat (2) @(negedge clk);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("rst_duty%0d", k), int'(duty[k]), 0);
         chk($sformatf("rst_dir%0d", k), int'(dir[k]), 0);
         chk($sformatf("rst_busy%0d", k), int'(busy[k]), 0);
         chk($sformatf("rst_done%0d", k), int'(done[k]), 0);
         chk($sformatf("rst_ready%0d", k), int'(rdy[k]), 0);
         chk($sformatf("rst_tick%0d", k), int'(tick[k]), 0);
         rst[k] = 1'b0;
      end
      @(negedge clk);
      for (int k = 0; k < N; k++) begin
         chk($sformatf("ready_after_rst%0d", k), int'(rdy[k]), 1);
         mon_en[k] = 1'b1;
      end

      fork
         begin : seq_a
            push(0, 256, 0, 0, 0, 1);
            push(0, 512, 0, 0, 1, 1);
            push(0, 768, 0, 0, 1, 1);
            push(0, 1000, 0, 1, 1, 1);
            send(0, 1000, 0);
            drain(0, "a_ramp_up");
            @(negedge clk);
            chk("a_busy_idle", int'(busy[0]), 0);
            chk("a_done_pulse_end", int'(done[0]), 0);
            push(0, 744, 0, 0, 0, 1);
            push(0, 488, 0, 0, 1, 1);
            push(0, 232, 0, 0, 1, 1);
            push(0, 0, 0, 0, 1, 1);
            push(0, 0, 1, 0, 2, 1);
            push(0, 256, 1, 0, 1, 1);
            push(0, 512, 1, 1, 1, 1);
            send(0, 512, 1);
            chk("a_ready_decel", int'(rdy[0]), 0);
            chk("a_busy_decel", int'(busy[0]), 1);
            tick_wait(0, 5);
            chk("a_ready_dead", int'(rdy[0]), 0);
            chk("a_dir_dead", int'(dir[0]), 0);
            drain(0, "a_reverse");
            @(negedge clk);
            chk("a_ready_end", int'(rdy[0]), 1);
            chk("a_busy_end", int'(busy[0]), 0);
         end
         begin : seq_b
            push(1, 1024, 0, 0, 0, 1);
            push(1, 2048, 0, 0, 1, 1);
            push(1, 3072, 0, 0, 1, 1);
            push(1, 4095, 0, 1, 1, 1);
            send(1, 4095, 0);
            drain(1, "b_up_sat");
            push(1, 3071, 0, 0, 0, 1);
            push(1, 2047, 0, 0, 1, 1);
            push(1, 1023, 0, 0, 1, 1);
            push(1, 0, 0, 1, 1, 1);
            send(1, 0, 0);
            drain(1, "b_down_sat");
            @(negedge clk);
            chk("b_busy_end", int'(busy[1]), 0);
         end
         begin : seq_c
            push(2, 256, 0, 0, 0, 1);
            push(2, 512, 0, 0, 1, 1);
            send(2, 1000, 0);
            drain(2, "c_pre_rst");
            repeat (5) @(negedge clk);
            push(2, 0, 0, 0, 0, 0);
            rst[2] = 1'b1;
            @(negedge clk);
            chk("c_busy_rst", int'(busy[2]), 0);
            chk("c_dir_rst", int'(dir[2]), 0);
            chk("c_ready_rst", int'(rdy[2]), 0);
            rst[2] = 1'b0;
            @(negedge clk);
            chk("c_ready_post_rst", int'(rdy[2]), 1);
            push(2, 256, 0, 0, 0, 1);
            push(2, 512, 0, 0, 1, 1);
            send(2, 1000, 0);
            drain(2, "c_ramp");
            tick_wait(2, 1);
            push(2, 600, 0, 1, 2, 1);
            chk("c_ready_on_tick", int'(rdy[2]), 1);
            vld[2]   = 1'b1;
            cduty[2] = W'(600);
            cdir[2]  = 1'b0;
            @(negedge clk);
            vld[2] = 1'b0;
            drain(2, "c_retarget");
            @(negedge clk);
            chk("c_busy_retarget", int'(busy[2]), 0);
`ifdef PWM_RAMP_ESTOP_EN
            push(2, 0, 0, 0, 0, 0);
            rst[2] = 1'b1;
            @(negedge clk);
            rst[2] = 1'b0;
            push(2, 256, 0, 0, 0, 1);
            push(2, 512, 0, 0, 1, 1);
            push(2, 768, 0, 0, 1, 1);
            send(2, 1000, 0);
            drain(2, "c_pre_estop");
            repeat (3) @(negedge clk);
            push(2, 0, 0, 0, 0, 0);
            estop = 1'b1;
            @(negedge clk);
            chk("c_ready_estop", int'(rdy[2]), 0);
            @(negedge clk);
            chk("c_ready_estop2", int'(rdy[2]), 0);
            estop = 1'b0;
            @(negedge clk);
            chk("c_busy_estop", int'(busy[2]), 0);
            chk("c_ready_estop_end", int'(rdy[2]), 1);
            tick_wait(2, 2);
            chk("c_duty_estop_hold", int'(duty[2]), 0);
`endif
         end
      join

      @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
